// File: rtl/phase_gen_pkg.sv
// phase_gen_pkg: shared types and limits for the 6502 two-phase clock generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package phase_gen_pkg;

  // INIT waits for the first clk0 fall. D12 and D21 are the dead gaps
  // between the phases: D12 follows P1 and D21 follows P2.
  typedef enum logic [2:0] {
    INIT = 3'd0,
    P1   = 3'd1,
    D12  = 3'd2,
    P2   = 3'd3,
    D21  = 3'd4
  } phase_state_t;

  // Legal dead-time range. The dead counter is 4 bits wide.
  localparam int DEAD_MIN = 1;
  localparam int DEAD_MAX = 15;

endpackage

// File: rtl/clk0_edge_det.sv
// clk0_edge_det: registers clk0 and flags its rising/falling edges.
// Latency: rise/fall are combinational from the live clk0 and the previous-cycle clk0_q.
// Backpressure: none.
// Ports: eclk, ereset_n (async, active-low) | clk0 in | rise, fall out.
module clk0_edge_det (
  input  logic eclk,
  input  logic ereset_n,
  input  logic clk0,
  output logic rise,
  output logic fall
);

  logic clk0_q;

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      clk0_q <= 1'b0;
    end else begin
      clk0_q <= clk0;
    end
  end

  assign rise = clk0 & ~clk0_q;
  assign fall = ~clk0 & clk0_q;

endmodule

// File: rtl/phase_gen_6502.sv
// phase_gen_6502: derives non-overlapping phi1/phi2, bus strobes and a CPU cycle count from clk0.
// Latency: all outputs registered; the active phase drops one eclk after the clk0 edge, and the other phase rises DEAD eclk later.
// Backpressure: none; free-running on eclk.
// Ports: eclk, ereset_n (async, active-low) | clk0, res (active-low CPU reset) in |
//        phi1, phi2, addr_strobe, data_strobe, cyc_count[CNT_W], err out.
// Build option: define PHASE_GEN_ERR_EN to build the sticky err flag; otherwise err is tied to 0.
module phase_gen_6502
  import phase_gen_pkg::*;
#(
  parameter int DEAD  = 2,   // dead time in eclk periods, DEAD_MIN..DEAD_MAX
  parameter int CNT_W = 32
) (
  input  logic             eclk,
  input  logic             ereset_n,
  input  logic             clk0,
  input  logic             res,
  output logic             phi1,
  output logic             phi2,
  output logic             addr_strobe,
  output logic             data_strobe,
  output logic [CNT_W-1:0] cyc_count,
  output logic             err
);

  // Terminal value of the dead counter. A dead state therefore lasts DEAD cycles.
  localparam logic [3:0] DEAD_LAST = 4'(DEAD - 1);

  phase_state_t state, state_nxt;
  logic [3:0]   dc, dc_nxt;
  logic         rise, fall;
  logic         err_set;

  clk0_edge_det u_edge (
    .eclk     (eclk),
    .ereset_n (ereset_n),
    .clk0     (clk0),
    .rise     (rise),
    .fall     (fall)
  );

  // Next-state logic. In a dead state, an opposite clk0 edge that arrives
  // before the gap has expired means the half-period is too short. The FSM
  // then skips the pending phase and restarts the other gap instead.
  always_comb begin
    state_nxt = state;
    dc_nxt    = dc;
    err_set   = 1'b0;
    case (state)
      INIT: begin
        // A rise here is ignored. The first full half-period starts at a fall.
        if (fall) begin
          state_nxt = D21;
          dc_nxt    = 4'd0;
        end
      end
      P1: begin
        if (rise) begin
          state_nxt = D12;
          dc_nxt    = 4'd0;
        end
      end
      D12: begin
        if (fall) begin
          state_nxt = D21;
          dc_nxt    = 4'd0;
          err_set   = 1'b1;
        end else if (dc == DEAD_LAST) begin
          state_nxt = P2;
          dc_nxt    = 4'd0;
        end else begin
          dc_nxt = dc + 4'd1;
        end
      end
      P2: begin
        if (fall) begin
          state_nxt = D21;
          dc_nxt    = 4'd0;
        end
      end
      D21: begin
        if (rise) begin
          state_nxt = D12;
          dc_nxt    = 4'd0;
          err_set   = 1'b1;
        end else if (dc == DEAD_LAST) begin
          state_nxt = P1;
          dc_nxt    = 4'd0;
        end else begin
          dc_nxt = dc + 4'd1;
        end
      end
      default: begin
        state_nxt = INIT;
        dc_nxt    = 4'd0;
      end
    endcase
  end

  // The phase and strobe flops load from the next state. Each one is then
  // aligned with the registered state it describes and cannot glitch.
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      state       <= INIT;
      dc          <= 4'd0;
      phi1        <= 1'b0;
      phi2        <= 1'b0;
      addr_strobe <= 1'b0;
      data_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      dc          <= dc_nxt;
      phi1        <= (state_nxt == P1);
      phi2        <= (state_nxt == P2);
      addr_strobe <= (state == D12) && (state_nxt == P2);
      data_strobe <= (state == P2)  && (state_nxt == D21);
    end
  end

  // A CPU cycle completes at the phi2 fall. The count is held at zero while
  // the CPU is in reset, so the clear has priority over the increment.
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      cyc_count <= '0;
    end else if (!res) begin
      cyc_count <= '0;
    end else if (data_strobe) begin
      cyc_count <= cyc_count + CNT_W'(1);
    end
  end

`ifdef PHASE_GEN_ERR_EN
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end
`else
  // The abort path still runs in this build. Only the report is dropped.
  logic unused_err_set;
  assign unused_err_set = err_set;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_phase_gen_6502.sv
// tb_phase_gen_6502: directed checks of phasing, strobes, cycle count, abort/err, async reset and counter wrap.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_phase_gen_6502;

  localparam int DEAD_M  = 2;
  localparam int HALF    = 10;
  localparam int RUN_EXP = HALF - DEAD_M;

  logic eclk = 1'b0;
  logic ereset_n, clk0, clk0_s, res;

  // main instance (DEAD=2, 32-bit count)
  logic phi1, phi2, addr_strobe, data_strobe, err;
  logic [31:0] cyc_count;
  // short-half-period instance (DEAD=4)
  logic phi1_s, phi2_s, astb_s, dstb_s, err_s;
  logic [31:0] cnt_s;
  // wrap instance (CNT_W=4), shares clk0/res with the main instance
  logic phi1_w, phi2_w, astb_w, dstb_w, err_w;
  logic [3:0] cnt_w;

  always #5 eclk = ~eclk;

  phase_gen_6502 #(.DEAD(DEAD_M), .CNT_W(32)) u_dut (
    .eclk(eclk), .ereset_n(ereset_n), .clk0(clk0), .res(res),
    .phi1(phi1), .phi2(phi2), .addr_strobe(addr_strobe), .data_strobe(data_strobe),
    .cyc_count(cyc_count), .err(err)
  );

  phase_gen_6502 #(.DEAD(4), .CNT_W(32)) u_short (
    .eclk(eclk), .ereset_n(ereset_n), .clk0(clk0_s), .res(res),
    .phi1(phi1_s), .phi2(phi2_s), .addr_strobe(astb_s), .data_strobe(dstb_s),
    .cyc_count(cnt_s), .err(err_s)
  );

  phase_gen_6502 #(.DEAD(DEAD_M), .CNT_W(4)) u_wrap (
    .eclk(eclk), .ereset_n(ereset_n), .clk0(clk0), .res(res),
    .phi1(phi1_w), .phi2(phi2_w), .addr_strobe(astb_w), .data_strobe(dstb_w),
    .cyc_count(cnt_w), .err(err_w)
  );

  // ---------------- monitor (sampled on the falling edge) ----------------
  int  p1_run = 0, p2_run = 0, gap = 0;
  bit  seen_phase = 1'b0;
  int  bad_runs = 0, bad_gaps = 0, overlaps = 0;
  int  astb_n = 0, dstb_n = 0, wide_n = 0;
  logic astb_prev = 1'b0, dstb_prev = 1'b0;
  int  p1s_n = 0, p2s_n = 0;

  always @(negedge eclk) begin
    if (phi1 && phi2) overlaps <= overlaps + 1;
    if (phi1) p1_run <= p1_run + 1;
    else if (p1_run > 0) begin
      if (p1_run != RUN_EXP) bad_runs <= bad_runs + 1;
      p1_run <= 0;
    end
    if (phi2) p2_run <= p2_run + 1;
    else if (p2_run > 0) begin
      if (p2_run != RUN_EXP) bad_runs <= bad_runs + 1;
      p2_run <= 0;
    end
    if (!phi1 && !phi2) begin
      if (seen_phase) gap <= gap + 1;
    end else begin
      seen_phase <= 1'b1;
      if (gap > 0) begin
        if (gap != DEAD_M) bad_gaps <= bad_gaps + 1;
        gap <= 0;
      end
    end
    if (addr_strobe) astb_n <= astb_n + 1;
    if (data_strobe) dstb_n <= dstb_n + 1;
    if ((addr_strobe && astb_prev) || (data_strobe && dstb_prev)) wide_n <= wide_n + 1;
    astb_prev <= addr_strobe;
    dstb_prev <= data_strobe;
    if (phi1_s) p1s_n <= p1s_n + 1;
    if (phi2_s) p2s_n <= p2s_n + 1;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge eclk);
    #1;
  endtask

  // A CPU cycle is a clk0 high half followed by a low half. The phi2 fall
  // and the count update land inside the low half.
  task automatic cpu_cycles(input int n);
    repeat (n) begin
      clk0 = 1'b1;
      step(HALF);
      clk0 = 1'b0;
      step(HALF);
    end
  endtask

  typedef struct {
    logic        res;
    int          ncyc;
    int          exp_astb;
    int          exp_dstb;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs [4];

  int a0, d0, w0, r0, g0, o0;
  int found;
  bit phi2_seen;
  logic exp_err_s;
  logic [3:0] wrap_exp [18];

  initial begin
    vecs[0] = '{1'b1, 5, 5, 5, 32'd5};   // strobes and count
    vecs[1] = '{1'b0, 3, 3, 3, 32'd0};   // CPU reset held: phases run, count held
    vecs[2] = '{1'b1, 2, 2, 2, 32'd2};   // release: counts from zero
    vecs[3] = '{1'b1, 3, 3, 3, 32'd5};
    for (int i = 0; i < 18; i++) wrap_exp[i] = 4'(i % 16);
`ifdef PHASE_GEN_ERR_EN
    exp_err_s = 1'b1;
`else
    exp_err_s = 1'b0;
`endif

    ereset_n = 1'b0;
    clk0     = 1'b0;
    clk0_s   = 1'b0;
    res      = 1'b0;
    step(3);

    // reset state
    check("rst_phi1", phi1, 0);
    check("rst_phi2", phi2, 0);
    check("rst_addr_strobe", addr_strobe, 0);
    check("rst_data_strobe", data_strobe, 0);
    check("rst_cyc_count", cyc_count, 0);
    check("rst_err", err, 0);

    ereset_n = 1'b1;
    step(2);
    // One warm-up cycle. The rise is ignored in INIT and the fall starts the phases.
    cpu_cycles(1);
    check("warmup_phi1", phi1, 1);

    for (int v = 0; v < 4; v++) begin
      a0 = astb_n; d0 = dstb_n; w0 = wide_n; r0 = bad_runs; g0 = bad_gaps; o0 = overlaps;
      res = vecs[v].res;
      cpu_cycles(vecs[v].ncyc);
      check($sformatf("v%0d_addr_strobes", v), astb_n - a0, vecs[v].exp_astb);
      check($sformatf("v%0d_data_strobes", v), dstb_n - d0, vecs[v].exp_dstb);
      check($sformatf("v%0d_cyc_count", v), cyc_count, vecs[v].exp_count);
      check($sformatf("v%0d_strobe_width", v), wide_n - w0, 0);
      check($sformatf("v%0d_phase_high_len", v), bad_runs - r0, 0);
      check($sformatf("v%0d_dead_gap_len", v), bad_gaps - g0, 0);
      check($sformatf("v%0d_overlap", v), overlaps - o0, 0);
    end
    check("main_err_clean", err, 0);

    // short half-period on the DEAD=4 instance: every dead gap aborts
    for (int i = 0; i < 10; i++) begin
      clk0_s = 1'b1;
      step(3);
      clk0_s = 1'b0;
      step(3);
    end
    check("short_phi2_cycles", p2s_n, 0);
    check("short_phi1_cycles", p1s_n, 0);
    check("short_err", err_s, exp_err_s);

    // async reset while phi2 is high
    res  = 1'b1;
    clk0 = 1'b1;
    phi2_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge eclk);
      if (phi2) begin
        phi2_seen = 1'b1;
        break;
      end
    end
    check("arst_phi2_reached", phi2_seen, 1);
    #1 ereset_n = 1'b0;
    #1;
    check("arst_phi2_low", phi2, 0);
    check("arst_phi1_low", phi1, 0);
    check("arst_cyc_count", cyc_count, 0);
    step(2);
    ereset_n = 1'b1;
    step(3);
    // clk0 is still high. The rise seen after release is ignored in INIT.
    check("arst_init_phi1", phi1, 0);
    check("arst_init_phi2", phi2, 0);
    clk0 = 1'b0;
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (phi1) begin
        found = k;
        break;
      end
    end
    check("arst_phi1_delay", found, DEAD_M + 1);

    // counter wrap on the 4-bit instance
    check("wrap_start", cnt_w, 0);
    for (int i = 1; i <= 17; i++) begin
      cpu_cycles(1);
      if (i >= 15) check($sformatf("wrap_after_%0d", i), cnt_w, wrap_exp[i]);
    end
    check("wide_count_no_wrap", cyc_count, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
